lcd_bus_arbiter: RTL
====================

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd1024: cycles allowed between spi_en_o and spi_done_i before abort; used only when LCD_ARB_TIMEOUT_EN is defined.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_i  in  2  per-requester write request, level, held until ack.
REQ-005 lock_i  in  2  per-requester burst lock; keeps the grant across consecutive words.
REQ-006 data0_i  in  9  requester 0 word {dc, byte}; dc=0 command, dc=1 data.
REQ-007 data1_i  in  9  requester 1 word, same format.
REQ-008 gnt_o  out  2  one-hot current grant, registered.
REQ-009 ack_o  out  2  one-cycle pulse: granted requester's word written.
REQ-010 spi_en_o  out  1  one-cycle start pulse to the shared SPI write engine.
REQ-011 spi_data_o  out  9  word presented to the SPI engine.
REQ-012 spi_done_i  in  1  one-cycle completion pulse from the SPI engine.
REQ-013 err_o  out  1  one-cycle timeout pulse.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT; one-hot encoding; unreachable encodings go to IDLE.
REQ-015 IDLE: no request -> stay, gnt_o=0; any req_i bit set -> pick winner, gnt_o one-hot next cycle, go ISSUE.
REQ-016 Arbitration round-robin: on simultaneous requests the requester not granted last wins; the last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-017 ISSUE: latch the winner's data into spi_data_o, pulse spi_en_o high for exactly one cycle, go WAIT.
REQ-018 Latency: req_i sampled in IDLE at cycle N -> gnt_o high at N+1 -> spi_en_o high at N+2.
REQ-019 spi_data_o holds its value from ISSUE until the next ISSUE.
REQ-020 WAIT: spi_done_i -> ack_o[winner] pulses one cycle; then if lock_i[winner] and req_i[winner] both high, keep the grant and go ISSUE; otherwise clear gnt_o, update the pointer, go IDLE.
REQ-021 Requester data changes in the cycle after ack_o; ISSUE samples the new word.
REQ-022 spi_done_i outside WAIT is ignored; no ack, no state change.
REQ-023 Winner dropping req_i during WAIT: the transfer completes and ack_o still pulses.
REQ-024 Non-granted requests wait; the held request is served on the next arbitration.
REQ-025 A locked burst of any length is never preempted; after it releases, the other requester wins the next tie.
REQ-026 At most one ack_o bit and at most one gnt_o bit high in any cycle.

Reset
REQ-027 rst_n low at a clock edge -> state IDLE, gnt_o=0, ack_o=0, spi_en_o=0, spi_data_o=9'd0, err_o=0, pointer=1, timeout counter=0.
REQ-028 Reset mid-WAIT abandons the transfer with no ack_o; a later spi_done_i is ignored per REQ-022.

Configuration
REQ-029 Macro LCD_ARB_TIMEOUT_EN defined: the counter clears on entry to WAIT and increments each WAIT cycle. On reaching TIMEOUT_CYC without spi_done_i: err_o pulses one cycle, no ack_o, grant cleared, pointer updated, go IDLE.
REQ-030 LCD_ARB_TIMEOUT_EN undefined: no counter logic, err_o tied 0, WAIT exits only on spi_done_i.

Verification
REQ-031 req_i=01, data0_i=9'h02A, done 5 cycles after spi_en_o -> gnt_o=01 at N+1, spi_en_o at N+2 with spi_data_o=02A, ack_o=01 one cycle, gnt_o=00 afterwards.
REQ-032 req_i=11 after reset -> requester 0 served first, requester 1 second; next tie served to 0 again.
REQ-033 Requester 1 lock_i=1, 4 words 1A0..1A3 while req_i[0] held -> four consecutive spi_en_o with those words, then requester 0 granted.
REQ-034 Spurious spi_done_i in IDLE and ISSUE -> no ack_o, no state change.
REQ-035 rst_n low for one cycle during WAIT -> all outputs reset next cycle; no ack_o for the aborted word.
REQ-036 LCD_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, spi_done_i never returned -> err_o pulses 16 cycles after WAIT entry, ack_o stays 0, FSM back in IDLE; macro undefined -> FSM stays in WAIT.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a shared SPI write engine, with burst lock.
// Define LCD_ARB_TIMEOUT_EN to abort a transfer whose spi_done_i never arrives.
module lcd_bus_arbiter #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  input  logic [8:0] data0_i,
  input  logic [8:0] data1_i,
  output logic [1:0] gnt_o,
  output logic [1:0] ack_o,
  output logic       spi_en_o,
  output logic [8:0] spi_data_o,
  input  logic       spi_done_i,
  output logic       err_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_ISSUE = 3'b010;
  localparam logic [2:0] ST_WAIT  = 3'b100;

  logic [2:0] state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       last_q, last_d;
  logic       spi_en_q, spi_en_d;
  logic [8:0] spi_data_q, spi_data_d;
  logic [1:0] pick;
  logic       win;
  logic       done_ack;

`ifdef LCD_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`else
  localparam logic unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  // last_q holds the index of the requester granted most recently; the other one wins a tie.
  always_comb begin
    pick = req_i;
    if (req_i == 2'b11) begin
      pick = last_q ? 2'b01 : 2'b10;
    end
  end

  assign win = gnt_q[1];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    spi_en_d   = 1'b0;
    spi_data_d = spi_data_q;
    done_ack   = 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_d = 2'b00;
        if (|req_i) begin
          gnt_d   = pick;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        spi_en_d   = 1'b1;
        spi_data_d = gnt_q[1] ? data1_i : data0_i;
        state_d    = ST_WAIT;
`ifdef LCD_ARB_TIMEOUT_EN
        cnt_d      = 16'd0;
`endif
      end
      ST_WAIT: begin
        if (spi_done_i) begin
          done_ack = 1'b1;
          if (lock_i[win] && req_i[win]) begin
            state_d = ST_ISSUE;
          end else begin
            gnt_d   = 2'b00;
            last_d  = win;
            state_d = ST_IDLE;
          end
        end
`ifdef LCD_ARB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
          err_d   = 1'b1;
          gnt_d   = 2'b00;
          last_d  = win;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 2'b00;
      last_q     <= 1'b1;
      spi_en_q   <= 1'b0;
      spi_data_q <= 9'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      spi_en_q   <= spi_en_d;
      spi_data_q <= spi_data_d;
    end
  end

`ifdef LCD_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // ack is combinational in the done cycle so a locked requester can present its next
  // word in the following cycle, which is the ISSUE cycle that samples it.
  assign ack_o      = done_ack ? gnt_q : 2'b00;
  assign gnt_o      = gnt_q;
  assign spi_en_o   = spi_en_q;
  assign spi_data_o = spi_data_q;
  assign state_o    = state_q;

endmodule
